// File: rtl/ws_array_if.sv
// Controller-side bundle for the 4x4 weight-stationary array sequencer:
// job control, weight buffer, activation source, PE edge signals and result sink.
interface ws_array_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int BW   = 8,
    parameter int AW   = 32,
    parameter int NW   = 16
);
    localparam int AXW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                       start_i;
    logic [NW-1:0]              num_vec_i;
    logic                       busy_o;
    logic                       done_o;
    logic                       wt_rd_o;
    logic [AXW-1:0]             wt_addr_o;
    logic [COLS-1:0][BW-1:0]    wt_rdata_i;
    logic                       act_valid_i;
    logic                       act_ready_o;
    logic [ROWS-1:0][BW-1:0]    act_data_i;
    logic                       pe_control_o;
    logic [COLS-1:0][BW-1:0]    pe_wt_o;
    logic [ROWS-1:0][BW-1:0]    pe_data_o;
    logic [COLS-1:0][AW-1:0]    pe_acc_i;
    logic                       res_valid_o;
    logic [COLS-1:0][AW-1:0]    res_data_o;

    modport slave (
        input  start_i, num_vec_i, wt_rdata_i, act_valid_i, act_data_i, pe_acc_i,
        output busy_o, done_o, wt_rd_o, wt_addr_o, act_ready_o,
               pe_control_o, pe_wt_o, pe_data_o, res_valid_o, res_data_o
    );

    modport master (
        output start_i, num_vec_i, wt_rdata_i, act_valid_i, act_data_i, pe_acc_i,
        input  busy_o, done_o, wt_rd_o, wt_addr_o, act_ready_o,
               pe_control_o, pe_wt_o, pe_data_o, res_valid_o, res_data_o
    );
endinterface

// File: rtl/ws_array_ctrl.sv
// Job sequencer for a weight-stationary systolic array: weight load, skewed
// activation streaming, and de-skew of bottom-row accumulations into result vectors.
module ws_dly_lane #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

module ws_array_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int BW   = 8,
    parameter int AW   = 32,
    parameter int NW   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    ws_array_if.slave  bus
);
    localparam int STAGES = ROWS + COLS;
    localparam int AXW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LCW    = $clog2(ROWS + 1);
    localparam int DCW    = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [AXW-1:0] LAST_ROW = AXW'(ROWS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic                    tag;
        logic [ROWS-1:0][BW-1:0] data;
    } slot_t;

    state_e                  state_q, state_d;
    logic [NW-1:0]           num_q, num_d;
    logic [NW-1:0]           acc_cnt_q, acc_cnt_d;
    logic [LCW-1:0]          load_cnt_q, load_cnt_d;
    logic [DCW-1:0]          drain_cnt_q, drain_cnt_d;

    logic                    wt_rd, pe_ctl, act_ready, accept, done;
    logic [AXW-1:0]          wt_addr;
    logic [COLS-1:0][BW-1:0] pe_wt;
    slot_t                   slot;

    logic [ROWS-1:0][BW-1:0] pe_data;
    logic [COLS-1:0][AW-1:0] aligned;
    logic [STAGES:0]         vld_pipe_q;
    logic [COLS-1:0][AW-1:0] res_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            acc_cnt_q   <= '0;
            load_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            acc_cnt_q   <= acc_cnt_d;
            load_cnt_q  <= load_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        acc_cnt_d   = acc_cnt_q;
        load_cnt_d  = load_cnt_q;
        drain_cnt_d = drain_cnt_q;
        wt_rd       = 1'b0;
        wt_addr     = '0;
        pe_ctl      = 1'b0;
        pe_wt       = '0;
        act_ready   = 1'b0;
        accept      = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    num_d      = bus.num_vec_i;
                    load_cnt_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                // Reads run one cycle ahead of control so the buffer latency lines up.
                wt_rd  = (load_cnt_q != LCW'(ROWS));
                pe_ctl = (load_cnt_q != '0);
                if (wt_rd)  wt_addr = LAST_ROW - load_cnt_q[AXW-1:0];
                if (pe_ctl) pe_wt   = bus.wt_rdata_i;
                if (load_cnt_q == LCW'(ROWS)) begin
                    acc_cnt_d   = '0;
                    drain_cnt_d = '0;
                    state_d     = (num_q == '0) ? S_DONE : S_STREAM;
                end else begin
                    load_cnt_d = load_cnt_q + LCW'(1);
                end
            end
            S_STREAM: begin
                act_ready = (acc_cnt_q < num_q);
                accept    = act_ready && bus.act_valid_i;
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + NW'(1);
                    if (acc_cnt_q == num_q - NW'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DCW'(STAGES - 1)) state_d = S_DONE;
                else drain_cnt_d = drain_cnt_q + DCW'(1);
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every cycle injects a slot; bubbles carry zero data and a cleared tag.
    always_comb begin
        slot.tag  = accept;
        slot.data = accept ? bus.act_data_i : '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        ws_dly_lane #(.W(BW), .DEPTH(r + 1)) u_lane (
            .clk, .rst_n, .d_i(slot.data[r]), .q_o(pe_data[r])
        );
    end

    // Column c finishes c cycles after column 0; delay the early ones to line up.
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        if (COLS - 1 - c > 0) begin : g_dly
            ws_dly_lane #(.W(AW), .DEPTH(COLS - 1 - c)) u_lane (
                .clk, .rst_n, .d_i(bus.pe_acc_i[c]), .q_o(aligned[c])
            );
        end else begin : g_pass
            assign aligned[c] = bus.pe_acc_i[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            res_data_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], slot.tag};
            if (vld_pipe_q[STAGES-1]) res_data_q <= aligned;
        end
    end

    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.done_o       = done;
    assign bus.wt_rd_o      = wt_rd;
    assign bus.wt_addr_o    = wt_addr;
    assign bus.act_ready_o  = act_ready;
    assign bus.pe_control_o = pe_ctl;
    assign bus.pe_wt_o      = pe_wt;
    assign bus.pe_data_o    = pe_data;
    assign bus.res_valid_o  = vld_pipe_q[STAGES];
    assign bus.res_data_o   = res_data_q;
endmodule

// File: tb/tb_ws_array_ctrl.sv
// Bench for ws_array_ctrl: weight buffer and 4x4 MAC array models around the
// controller, job table with hand-computed results, plus abort/reset sequence.
module tb_ws_array_ctrl;
    localparam int ROWS = 4, COLS = 4, BW = 8, AW = 32, NW = 16;
    localparam int LAT  = ROWS + COLS + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ws_array_if #(.ROWS(ROWS), .COLS(COLS), .BW(BW), .AW(AW), .NW(NW)) bus ();

    ws_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .BW(BW), .AW(AW), .NW(NW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Weight buffer, read latency 1.
    logic [3:0][3:0][7:0] wbuf;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.wt_rdata_i <= '0;
        else if (bus.wt_rd_o) bus.wt_rdata_i <= wbuf[bus.wt_addr_o];
    end

    // Array: weights shift down under control, activations move right, sums move down.
    logic [7:0]  pw [4][4];
    logic [7:0]  pa [4][4];
    logic [31:0] ps [4][4];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    pw[r][c] <= '0; pa[r][c] <= '0; ps[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    int rp, cp;
                    logic [7:0] ain;
                    logic [7:0] win;
                    logic [31:0] sin;
                    rp  = (r == 0) ? 0 : r - 1;
                    cp  = (c == 0) ? 0 : c - 1;
                    ain = (c == 0) ? bus.pe_data_o[r] : pa[r][cp];
                    win = (r == 0) ? bus.pe_wt_o[c] : pw[rp][c];
                    sin = (r == 0) ? 32'd0 : ps[rp][c];
                    if (bus.pe_control_o) pw[r][c] <= win;
                    pa[r][c] <= ain;
                    ps[r][c] <= sin + 32'(ain) * 32'(pw[r][c]);
                end
        end
    end
    always_comb for (int c = 0; c < 4; c++) bus.pe_acc_i[c] = ps[3][c];

    typedef struct {
        string                 name;
        int                    nv;
        bit                    gap;
        bit                    spur;
        logic [3:0][3:0][7:0]  wts;   // [row][col]
        logic [3:0][3:0][7:0]  acts;  // [vector][row]
        logic [3:0][3:0][31:0] exp;   // [vector][col]
    } job_t;

    job_t jobs[6];

    task automatic run_job(input int j);
        job_t jb = jobs[j];
        int vi = 0, nb = 0, nrd = 0, rd_seq = 0, nctl = 0, done_n = -1;
        bit bad_ld = 0, rdy_seen = 0;
        int acyc[4];
        int bcyc[4];
        logic [3:0][31:0] bdat[4];
        for (int v = 0; v < 4; v++) begin acyc[v] = -100; bcyc[v] = 0; bdat[v] = '0; end
        wbuf = jb.wts;
        @(negedge clk);
        bus.start_i = 1'b1; bus.num_vec_i = 16'(jb.nv); bus.act_valid_i = 1'b0;
        for (int k = 1; k <= 80 && done_n < 0; k++) begin
            @(negedge clk);
            bus.start_i   = jb.spur && (k == 3 || k == 8);
            bus.num_vec_i = jb.spur ? 16'd3 : 16'(jb.nv);
            if (bus.wt_rd_o) begin rd_seq = rd_seq * 4 + int'(bus.wt_addr_o); nrd++; end
            if (bus.pe_control_o) nctl++;
            if ((bus.wt_rd_o || bus.pe_control_o) && bus.pe_data_o != '0) bad_ld = 1;
            if (bus.act_ready_o) rdy_seen = 1;
            if (bus.res_valid_o) begin
                if (nb < 4) begin bdat[nb] = bus.res_data_o; bcyc[nb] = k; end
                nb++;
            end
            if (bus.done_o) done_n = k;
            if (vi < jb.nv && (!jb.gap || (k % 2 == 1))) begin
                bus.act_valid_i = 1'b1;
                bus.act_data_i  = jb.acts[vi];
                if (bus.act_ready_o) begin acyc[vi] = k; vi++; end
            end else begin
                bus.act_valid_i = 1'b0;
                bus.act_data_i  = '0;
            end
        end
        bus.start_i = 1'b0;
        chk({jb.name, " done_seen"}, 128'(done_n >= 0), 128'(1));
        chk({jb.name, " rd_count"}, 128'(nrd), 128'(4));
        chk({jb.name, " rd_addr_order"}, 128'(rd_seq), 128'(228));
        chk({jb.name, " ctl_cycles"}, 128'(nctl), 128'(4));
        chk({jb.name, " pe_data_in_load"}, 128'(bad_ld), 128'(0));
        chk({jb.name, " beat_count"}, 128'(nb), 128'(jb.nv));
        for (int v = 0; v < jb.nv && v < nb && v < 4; v++) begin
            chk({jb.name, " res_data"}, 128'(bdat[v]), 128'(jb.exp[v]));
            chk({jb.name, " latency"}, 128'(bcyc[v] - acyc[v]), 128'(LAT));
        end
        if (jb.nv == 0) begin
            chk({jb.name, " no_ready"}, 128'(rdy_seen), 128'(0));
            chk({jb.name, " load_to_done"}, 128'(done_n), 128'(ROWS + 2));
        end else if (nb > 0 && nb <= 4) begin
            chk({jb.name, " done_not_before_beat"}, 128'(bcyc[nb-1] <= done_n), 128'(1));
        end
        @(negedge clk);
        chk({jb.name, " done_pulse_busy_clear"}, 128'({bus.done_o, bus.busy_o}), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int vi;
        bus.start_i = 1'b0; bus.num_vec_i = '0;
        bus.act_valid_i = 1'b0; bus.act_data_i = '0;
        wbuf = '0;

        foreach (jobs[j]) begin
            jobs[j].nv = 0; jobs[j].gap = 0; jobs[j].spur = 0;
            jobs[j].wts = '0; jobs[j].acts = '0; jobs[j].exp = '0;
        end
        jobs[0].name = "ones";  jobs[0].nv = 1; jobs[0].spur = 1;
        jobs[1].name = "ident"; jobs[1].nv = 4;
        jobs[2].name = "gap";   jobs[2].nv = 4; jobs[2].gap = 1;
        jobs[3].name = "zero";  jobs[3].nv = 0;
        jobs[4].name = "max";   jobs[4].nv = 2;
        jobs[5].name = "ramp";  jobs[5].nv = 1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                jobs[0].wts[r][c]  = 8'(r + 1);
                jobs[0].acts[0][r] = 8'd1;
                jobs[0].exp[0][c]  = 32'd10;
                jobs[1].wts[r][c]  = (r == c) ? 8'd1 : 8'd0;
                jobs[3].wts[r][c]  = 8'(r + 1);
                jobs[4].wts[r][c]  = 8'd255;
                jobs[5].wts[r][c]  = 8'(4 * r + c + 1);
                jobs[5].acts[0][r] = 8'(r + 1);
            end
        for (int v = 0; v < 4; v++)
            for (int r = 0; r < 4; r++) begin
                jobs[1].acts[v][r] = 8'(4 * v + r + 1);
                jobs[1].exp[v][r]  = 32'(4 * v + r + 1);
            end
        for (int v = 0; v < 2; v++)
            for (int r = 0; r < 4; r++) begin
                jobs[4].acts[v][r] = 8'd255;
                jobs[4].exp[v][r]  = 32'd260100;
            end
        jobs[5].exp[0] = {32'd120, 32'd110, 32'd100, 32'd90};
        jobs[2].wts  = jobs[1].wts;
        jobs[2].acts = jobs[1].acts;
        jobs[2].exp  = jobs[1].exp;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", 128'({bus.busy_o, bus.done_o, bus.wt_rd_o, bus.act_ready_o,
                                bus.pe_control_o, bus.res_valid_o}), 128'(0));
        chk("reset_res_data", 128'(bus.res_data_o), 128'(0));
        chk("reset_pe_bus", 128'({bus.pe_wt_o, bus.pe_data_o, bus.wt_addr_o}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 128'(bus.busy_o), 128'(0));

        for (int j = 0; j < 6; j++) run_job(j);

        // Abort mid-STREAM with two vectors in flight.
        wbuf = jobs[1].wts;
        @(negedge clk);
        bus.start_i = 1'b1; bus.num_vec_i = 16'd4;
        vi = 0;
        for (int k = 1; k <= 40 && vi < 2; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            bus.act_valid_i = 1'b1;
            bus.act_data_i  = jobs[1].acts[vi];
            if (bus.act_ready_o) vi++;
        end
        chk("abort_accepts", 128'(vi), 128'(2));
        @(negedge clk);
        bus.act_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", 128'({bus.busy_o, bus.done_o, bus.wt_rd_o, bus.act_ready_o,
                                bus.pe_control_o, bus.res_valid_o}), 128'(0));
        chk("abort_data", 128'({bus.pe_data_o, bus.pe_wt_o}), 128'(0));
        chk("abort_res", 128'(bus.res_data_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.done_o || bus.res_valid_o || bus.busy_o) break;
        end
        chk("abort_quiet", 128'({bus.done_o, bus.res_valid_o, bus.busy_o}), 128'(0));

        run_job(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
